uncache_dm_ctrl: RTL and testbench

//  Uncached data-access engine in the MEM2 stage. Consumes uncache_valid/DMWen_uncache from MEM2 request

---
 rtl/uncache_dm_ctrl_pkg.sv | 18 +
 rtl/uncache_wbuf.sv | 17 +
 rtl/uncache_dm_ctrl.sv | 142 ++++++++++++++
 tb/tb_uncache_dm_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uncache_dm_ctrl_pkg.sv
// Shared encodings for the uncached data-access engine.
// Consumers: uncache_dm_ctrl and uncache_wbuf.
package uncache_dm_ctrl_pkg;

  typedef enum logic [2:0] {
    UNC_IDLE    = 3'd0,
    UNC_RD_REQ  = 3'd1,
    UNC_RD_WAIT = 3'd2,
    UNC_WR_REQ  = 3'd3,
    UNC_WR_WAIT = 3'd4,
    UNC_DONE    = 3'd5
  } unc_state_e;

  localparam logic [2:0]  UNC_RD_TYPE_DEF = 3'b010;
  localparam logic [2:0]  UNC_WR_TYPE_DEF = 3'b010;
  localparam logic [31:0] RDATA_RST_DEF   = 32'h0;

endpackage

// File: rtl/uncache_wbuf.sv
// Outstanding posted-write tracker, used only when UNCACHE_WBUF_EN is defined.
// A set in the same cycle as clr wins, so the flag stays set.
module uncache_wbuf (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end

endmodule

// File: rtl/uncache_dm_ctrl.sv
// Single-beat uncached read/write engine for MEM2.
// Optional macro UNCACHE_WBUF_EN: posted writes tracked by uncache_wbuf.
module uncache_dm_ctrl
  import uncache_dm_ctrl_pkg::*;
#(
  parameter logic [2:0]  UNC_RD_TYPE = UNC_RD_TYPE_DEF,
  parameter logic [2:0]  UNC_WR_TYPE = UNC_WR_TYPE_DEF,
  parameter logic [31:0] RDATA_RST   = RDATA_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uncache_valid,
  input  logic        DMWen_uncache,
  input  logic [31:0] MEM2_Paddr,
  input  logic [3:0]  MEM2_wstrb,
  input  logic [31:0] MEM2_wdata,
  input  logic        MEM2_allowout,
  output logic        MEM_unCache_data_ok,
  output logic [31:0] uncache_Out,
  output logic        uncache_rd_req,
  output logic [2:0]  uncache_rd_type,
  output logic [31:0] uncache_rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic [31:0] ret_data,
  output logic        uncache_wr_req,
  output logic [2:0]  uncache_wr_type,
  output logic [31:0] uncache_wr_addr,
  output logic [3:0]  uncache_wr_wstrb,
  output logic [31:0] uncache_wr_data,
  input  logic        wr_rdy,
  input  logic        wr_ok,
  output unc_state_e  dbg_state
);

  // Handshake: a request is held high with stable fields from the latches until
  // the matching rdy is seen on a rising edge; requests are decoded from
  // registered state only, so no input reaches a request output combinationally.
  unc_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, out_q;
  logic [3:0]  wstrb_q;
  logic        accept;

`ifdef UNCACHE_WBUF_EN
  logic wr_busy, wr_set;

  uncache_wbuf u_wbuf (
    .clk  (clk),
    .rst  (rst),
    .set  (wr_set),
    .clr  (wr_ok),
    .busy (wr_busy)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNC_IDLE;
      addr_q  <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      out_q   <= RDATA_RST;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= MEM2_Paddr;
        wstrb_q <= MEM2_wstrb;
        wdata_q <= MEM2_wdata;
      end
      if (state_q == UNC_RD_WAIT && ret_valid) out_q <= ret_data;
    end
  end

  always_comb begin
    state_d             = state_q;
    accept              = 1'b0;
    MEM_unCache_data_ok = 1'b0;
    uncache_rd_req      = 1'b0;
    uncache_wr_req      = 1'b0;
`ifdef UNCACHE_WBUF_EN
    wr_set              = 1'b0;
`endif
    case (state_q)
      UNC_IDLE: begin
        MEM_unCache_data_ok = ~uncache_valid;
        if (uncache_valid) begin
`ifdef UNCACHE_WBUF_EN
          // Reads must not overtake a posted write still in flight.
          if (DMWen_uncache) begin
            accept  = 1'b1;
            state_d = UNC_WR_REQ;
          end else if (!wr_busy) begin
            accept  = 1'b1;
            state_d = UNC_RD_REQ;
          end
`else
          accept  = 1'b1;
          state_d = DMWen_uncache ? UNC_WR_REQ : UNC_RD_REQ;
`endif
        end
      end
      UNC_RD_REQ: begin
        uncache_rd_req = 1'b1;
        if (rd_rdy) state_d = UNC_RD_WAIT;
      end
      UNC_RD_WAIT: begin
        if (ret_valid) state_d = UNC_DONE;
      end
      UNC_WR_REQ: begin
`ifdef UNCACHE_WBUF_EN
        // Only one posted write may be outstanding; the next waits for wr_ok.
        uncache_wr_req = ~wr_busy;
        if (wr_rdy && !wr_busy) begin
          wr_set  = 1'b1;
          state_d = UNC_DONE;
        end
`else
        uncache_wr_req = 1'b1;
        if (wr_rdy) state_d = UNC_WR_WAIT;
`endif
      end
      UNC_WR_WAIT: begin
        if (wr_ok) state_d = UNC_DONE;
      end
      UNC_DONE: begin
        MEM_unCache_data_ok = 1'b1;
        if (MEM2_allowout) state_d = UNC_IDLE;
      end
      default: state_d = UNC_IDLE;
    endcase
  end

  assign uncache_Out      = out_q;
  assign uncache_rd_type  = UNC_RD_TYPE;
  assign uncache_rd_addr  = addr_q;
  assign uncache_wr_type  = UNC_WR_TYPE;
  assign uncache_wr_addr  = addr_q;
  assign uncache_wr_wstrb = wstrb_q;
  assign uncache_wr_data  = wdata_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_uncache_dm_ctrl.sv
// Directed bench for uncache_dm_ctrl; posted-write expectations follow UNCACHE_WBUF_EN.
module tb_uncache_dm_ctrl;
  import uncache_dm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uncache_valid = 1'b0;
  logic        DMWen_uncache = 1'b0;
  logic [31:0] MEM2_Paddr = 32'h0;
  logic [3:0]  MEM2_wstrb = 4'h0;
  logic [31:0] MEM2_wdata = 32'h0;
  logic        MEM2_allowout = 1'b0;
  logic        MEM_unCache_data_ok;
  logic [31:0] uncache_Out;
  logic        uncache_rd_req;
  logic [2:0]  uncache_rd_type;
  logic [31:0] uncache_rd_addr;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_data = 32'h0;
  logic        uncache_wr_req;
  logic [2:0]  uncache_wr_type;
  logic [31:0] uncache_wr_addr;
  logic [3:0]  uncache_wr_wstrb;
  logic [31:0] uncache_wr_data;
  logic        wr_rdy = 1'b0;
  logic        wr_ok = 1'b0;
  unc_state_e  dbg_state;

  int errors = 0;
  int checks = 0;

  uncache_dm_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .uncache_valid       (uncache_valid),
    .DMWen_uncache       (DMWen_uncache),
    .MEM2_Paddr          (MEM2_Paddr),
    .MEM2_wstrb          (MEM2_wstrb),
    .MEM2_wdata          (MEM2_wdata),
    .MEM2_allowout       (MEM2_allowout),
    .MEM_unCache_data_ok (MEM_unCache_data_ok),
    .uncache_Out         (uncache_Out),
    .uncache_rd_req      (uncache_rd_req),
    .uncache_rd_type     (uncache_rd_type),
    .uncache_rd_addr     (uncache_rd_addr),
    .rd_rdy              (rd_rdy),
    .ret_valid           (ret_valid),
    .ret_data            (ret_data),
    .uncache_wr_req      (uncache_wr_req),
    .uncache_wr_type     (uncache_wr_type),
    .uncache_wr_addr     (uncache_wr_addr),
    .uncache_wr_wstrb    (uncache_wr_wstrb),
    .uncache_wr_data     (uncache_wr_data),
    .wr_rdy              (wr_rdy),
    .wr_ok               (wr_ok),
    .dbg_state           (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(UNC_IDLE));
    chk("rst_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
    chk("rst_rd_req", 32'(uncache_rd_req), 32'd0);
    chk("rst_wr_req", 32'(uncache_wr_req), 32'd0);
    chk("rst_out", uncache_Out, 32'h0);
    rst = 1'b0;
    tick();

    // test 6 first part: stray responses in IDLE
    ret_valid = 1'b1; ret_data = 32'hCAFE_F00D; wr_ok = 1'b1;
    tick();
    ret_valid = 1'b0; wr_ok = 1'b0;
    chk("stray_state", 32'(dbg_state), 32'(UNC_IDLE));
    chk("stray_out", uncache_Out, 32'h0);

    // test 1: read with delayed accept and data
    uncache_valid = 1'b1; DMWen_uncache = 1'b0; MEM2_Paddr = 32'h1faf_0004;
    #1;
    chk("rd_idle_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    tick();
    chk("rd_req_hi0", 32'(uncache_rd_req), 32'd1);
    chk("rd_addr", uncache_rd_addr, 32'h1faf_0004);
    chk("rd_type", 32'(uncache_rd_type), 32'd2);
    chk("rd_req_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    tick();
    chk("rd_req_hi1", 32'(uncache_rd_req), 32'd1);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    chk("rd_req_dropped", 32'(uncache_rd_req), 32'd0);
    chk("rd_wait_state", 32'(dbg_state), 32'(UNC_RD_WAIT));
    tick();
    tick();
    chk("rd_wait_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    ret_valid = 1'b1; ret_data = 32'hDEAD_BEEF;
    tick();
    ret_valid = 1'b0;
    chk("rd_out", uncache_Out, 32'hDEAD_BEEF);
    chk("rd_done_data_ok", 32'(MEM_unCache_data_ok), 32'd1);

    // test 3: DONE stalled by MEM2_allowout=0
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
      chk("stall_no_rd_req", 32'(uncache_rd_req), 32'd0);
      chk("stall_state", 32'(dbg_state), 32'(UNC_DONE));
    end
    uncache_valid = 1'b0; MEM2_allowout = 1'b1;
    tick();
    MEM2_allowout = 1'b0;
    chk("release_state", 32'(dbg_state), 32'(UNC_IDLE));
    chk("release_data_ok", 32'(MEM_unCache_data_ok), 32'd1);

    // earliest read; rd_rdy with ret_valid in RD_REQ is an accept only
    uncache_valid = 1'b1; MEM2_Paddr = 32'h1faf_0010;
    tick();
    rd_rdy = 1'b1; ret_valid = 1'b1; ret_data = 32'h1111_1111;
    tick();
    rd_rdy = 1'b0; ret_data = 32'h2222_2222;
    chk("fast_wait_state", 32'(dbg_state), 32'(UNC_RD_WAIT));
    chk("fast_out_held", uncache_Out, 32'hDEAD_BEEF);
    chk("fast_wait_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    tick();
    ret_valid = 1'b0;
    chk("fast_out", uncache_Out, 32'h2222_2222);
    chk("fast_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
    uncache_valid = 1'b0; MEM2_allowout = 1'b1;
    tick();
    MEM2_allowout = 1'b0;

    // test 2: write with stable latched fields
    uncache_valid = 1'b1; DMWen_uncache = 1'b1; MEM2_Paddr = 32'h1faf_0008;
    MEM2_wstrb = 4'b1100; MEM2_wdata = 32'h1234_0000;
    tick();
    MEM2_Paddr = 32'h0; MEM2_wstrb = 4'h0; MEM2_wdata = 32'hFFFF_FFFF;
    chk("wr_req_hi", 32'(uncache_wr_req), 32'd1);
    chk("wr_addr", uncache_wr_addr, 32'h1faf_0008);
    chk("wr_wstrb", 32'(uncache_wr_wstrb), 32'hC);
    chk("wr_data", uncache_wr_data, 32'h1234_0000);
    chk("wr_type", 32'(uncache_wr_type), 32'd2);
    tick();
    chk("wr_req_hold", 32'(uncache_wr_req), 32'd1);
    chk("wr_data_hold", uncache_wr_data, 32'h1234_0000);
    chk("wr_req_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    wr_rdy = 1'b1;
    tick();
    wr_rdy = 1'b0;
    chk("wr_req_dropped", 32'(uncache_wr_req), 32'd0);
`ifdef UNCACHE_WBUF_EN
    chk("wr_posted_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
    uncache_valid = 1'b0; MEM2_allowout = 1'b1;
    tick();
    MEM2_allowout = 1'b0;

    // test 4: read behind an outstanding posted write
    uncache_valid = 1'b1; DMWen_uncache = 1'b0; MEM2_Paddr = 32'h1faf_000c;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wb_rd_blocked", 32'(uncache_rd_req), 32'd0);
      chk("wb_blocked_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    end
    wr_ok = 1'b1;
    tick();
    wr_ok = 1'b0;
    chk("wb_rd_after_ok0", 32'(uncache_rd_req), 32'd0);
    tick();
    chk("wb_rd_after_ok1", 32'(uncache_rd_req), 32'd1);
    chk("wb_rd_addr", uncache_rd_addr, 32'h1faf_000c);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0; ret_valid = 1'b1; ret_data = 32'h5555_AAAA;
    tick();
    ret_valid = 1'b0;
    chk("wb_rd_out", uncache_Out, 32'h5555_AAAA);
`else
    chk("wr_wait_state", 32'(dbg_state), 32'(UNC_WR_WAIT));
    tick();
    tick();
    chk("wr_wait_data_ok", 32'(MEM_unCache_data_ok), 32'd0);
    wr_ok = 1'b1;
    tick();
    wr_ok = 1'b0;
    chk("wr_done_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
`endif
    uncache_valid = 1'b0; MEM2_allowout = 1'b1;
    tick();
    MEM2_allowout = 1'b0;

    // test 5: reset in RD_WAIT, late response discarded
    uncache_valid = 1'b1; DMWen_uncache = 1'b0; MEM2_Paddr = 32'h1faf_0020;
    tick();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    chk("pre_rst_state", 32'(dbg_state), 32'(UNC_RD_WAIT));
    uncache_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(dbg_state), 32'(UNC_IDLE));
    chk("arst_rd_req", 32'(uncache_rd_req), 32'd0);
    chk("arst_out", uncache_Out, 32'h0);
    chk("arst_data_ok", 32'(MEM_unCache_data_ok), 32'd1);
    tick();
    rst = 1'b0;
    ret_valid = 1'b1; ret_data = 32'hBAD0_BAD0; wr_ok = 1'b1;
    tick();
    ret_valid = 1'b0; wr_ok = 1'b0;
    chk("late_state", 32'(dbg_state), 32'(UNC_IDLE));
    chk("late_out", uncache_Out, 32'h0);
    chk("late_wr_req", 32'(uncache_wr_req), 32'd0);
    chk("late_data_ok", 32'(MEM_unCache_data_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
